spi_eeprom_slave: RTL and testbench

SPI_EEPROM_SLAVE -- requirements
Module: spi_eeprom_slave

---
 rtl/spi_eeprom_if.sv | 13 +
 rtl/spi_eeprom_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_eeprom_slave.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_eeprom_if.sv
// SPI bus bundle for the EEPROM slave: master-driven sck/csn/mosi and
// slave-driven miso, miso_oe and the busy (WIP) mirror.
interface spi_eeprom_if;
    logic sck;
    logic csn;
    logic mosi;
    logic miso;
    logic miso_oe;
    logic busy;

    modport master (output sck, csn, mosi, input miso, miso_oe, busy);
    modport slave  (input sck, csn, mosi, output miso, miso_oe, busy);
endinterface

// File: rtl/spi_eeprom_slave.sv
// SPI mode-0 EEPROM slave, 128x8 array, 16-byte write pages, status register
// {4'b0, BP1, BP0, WEL, WIP}. All logic runs on clk; SPI pins are synchronized.
// Optional feature: define SPI_EEPROM_WRSR_EN to enable WRSR (0x01) and
// block-protect checking on writes.
module spi_eeprom_slave #(
    parameter int WRITE_CYCLES = 64
) (
    input logic         clk,
    input logic         rst_n,
    spi_eeprom_if.slave bus
);
    localparam int CW = $clog2(WRITE_CYCLES + 1);

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
`ifdef SPI_EEPROM_WRSR_EN
    localparam logic [7:0] OP_WRSR  = 8'h01;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, STAT, IGNORE} state_t;
    typedef enum logic [1:0] {P_NONE, P_WREN, P_WRDI} pend_t;

    logic [1:0]    sck_sync, csn_sync, mosi_sync;
    logic          sck_d, csn_d;
    logic          sck_rise, sck_fall, csn_rise, csn_fall;
    logic [7:0]    rx_byte;

    state_t        state;
    pend_t         pend;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    cmd;
    logic [6:0]    addr;
    logic [7:0]    tx_sh;
    logic          miso_q, miso_oe_q;
    logic          wel, wip;
    logic [1:0]    bp;
    logic [CW-1:0] wr_cnt;
    logic          wr_any;     // at least one byte committed in this frame
    logic [7:0]    status;
    logic          blocked;
    logic          mem_we;

    logic [7:0]    mem [128];

    // Two-flop synchronizers plus one delay stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= 2'b00;
            csn_sync  <= 2'b11;
            mosi_sync <= 2'b00;
            sck_d     <= 1'b0;
            csn_d     <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[0], bus.sck};
            csn_sync  <= {csn_sync[0], bus.csn};
            mosi_sync <= {mosi_sync[0], bus.mosi};
            sck_d     <= sck_sync[1];
            csn_d     <= csn_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_d;
    assign sck_fall = ~sck_sync[1] & sck_d;
    assign csn_rise = csn_sync[1] & ~csn_d;
    assign csn_fall = ~csn_sync[1] & csn_d;
    assign rx_byte  = {shreg[6:0], mosi_sync[1]};
    assign status   = {4'b0000, bp, wel, wip};

    // Block-protect decode for the current write address
    always_comb begin
        blocked = 1'b0;
`ifdef SPI_EEPROM_WRSR_EN
        case (bp)
            2'b01:   blocked = (addr >= 7'h60);
            2'b10:   blocked = (addr >= 7'h40);
            2'b11:   blocked = 1'b1;
            default: blocked = 1'b0;
        endcase
`endif
    end

    // Array write strobe: 8th rise of a data byte in a WRITE frame
    always_comb begin
        mem_we = 1'b0;
        if (!csn_rise && sck_rise && state == WDATA && bit_cnt == 3'd7 &&
            cmd == OP_WRITE && !blocked)
            mem_we = 1'b1;
    end

    // Memory array, intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr] <= rx_byte;
    end

    // Frame FSM, status register and write-cycle timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= P_NONE;
            bit_cnt   <= '0;
            shreg     <= '0;
            cmd       <= '0;
            addr      <= '0;
            tx_sh     <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            wel       <= 1'b0;
            wip       <= 1'b0;
            bp        <= 2'b00;
            wr_cnt    <= '0;
            wr_any    <= 1'b0;
        end else begin
            // WIP stays set for exactly WRITE_CYCLES clk cycles
            if (wip) begin
                if (wr_cnt <= CW'(1)) begin
                    wip    <= 1'b0;
                    wr_cnt <= '0;
                end else begin
                    wr_cnt <= wr_cnt - CW'(1);
                end
            end

            if (csn_rise) begin
                // Frame end: WREN/WRDI only take effect for exact 8-bit frames
                state     <= IDLE;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
                pend      <= P_NONE;
                if (pend == P_WREN)
                    wel <= 1'b1;
                else if (pend == P_WRDI)
                    wel <= 1'b0;
                if (wr_any) begin
                    wip    <= 1'b1;
                    wel    <= 1'b0;
                    wr_cnt <= CW'(WRITE_CYCLES);
                    wr_any <= 1'b0;
                end
            end else if (state == IDLE) begin
                if (csn_fall) begin
                    state   <= CMD;
                    bit_cnt <= '0;
                    wr_any  <= 1'b0;
                    pend    <= P_NONE;
                end
            end else begin
                if (sck_rise) begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                    pend    <= P_NONE;   // any bit beyond the 8th cancels WREN/WRDI
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            CMD: begin
                                cmd <= rx_byte;
                                if (wip && rx_byte != OP_RDSR) begin
                                    state <= IGNORE;
                                end else begin
                                    case (rx_byte)
                                        OP_WREN: begin pend <= P_WREN; state <= IGNORE; end
                                        OP_WRDI: begin pend <= P_WRDI; state <= IGNORE; end
                                        OP_RDSR: begin state <= STAT; tx_sh <= status; end
                                        OP_READ:  state <= ADDR;
                                        OP_WRITE: state <= wel ? ADDR : IGNORE;
`ifdef SPI_EEPROM_WRSR_EN
                                        OP_WRSR:  state <= wel ? WDATA : IGNORE;
`endif
                                        default:  state <= IGNORE;
                                    endcase
                                end
                            end
                            ADDR: begin
                                addr <= rx_byte[6:0];
                                if (cmd == OP_READ) begin
                                    state <= RDATA;
                                    tx_sh <= mem[rx_byte[6:0]];
                                end else begin
                                    state <= WDATA;
                                end
                            end
                            WDATA: begin
`ifdef SPI_EEPROM_WRSR_EN
                                if (cmd == OP_WRSR) begin
                                    bp     <= rx_byte[3:2];
                                    wr_any <= 1'b1;
                                    state  <= IGNORE;
                                end else
`endif
                                begin
                                    if (!blocked)
                                        wr_any <= 1'b1;
                                    addr <= {addr[6:4], addr[3:0] + 4'd1};
                                end
                            end
                            RDATA: begin
                                addr  <= addr + 7'd1;
                                tx_sh <= mem[addr + 7'd1];
                            end
                            STAT:    tx_sh <= status;
                            default: ;
                        endcase
                    end
                end else if (sck_fall && (state == RDATA || state == STAT)) begin
                    miso_q    <= tx_sh[7];
                    tx_sh     <= {tx_sh[6:0], 1'b0};
                    miso_oe_q <= 1'b1;
                end
            end
        end
    end

    assign bus.miso    = miso_q;
    assign bus.miso_oe = miso_oe_q;
    assign bus.busy    = wip;

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// Directed bench for spi_eeprom_slave; define SPI_EEPROM_WRSR_EN to also
// exercise WRSR and block protection.
module tb_spi_eeprom_slave;
    localparam int WC = 300;
    localparam time H = 60ns;   // sck half period, 6 clk

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_cyc = 0;

    spi_eeprom_if bus ();

    spi_eeprom_slave #(.WRITE_CYCLES(WC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5ns clk = ~clk;

    // Running count of clk cycles with busy high
    always @(negedge clk) if (bus.busy === 1'b1) busy_cyc++;

    task automatic spi_bit(input logic b, output logic r);
        bus.mosi = b;
        #H;
        r = bus.miso;
        bus.sck = 1'b1;
        #H;
        bus.sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
    endtask

    task automatic fstart();
        @(negedge clk);
        bus.csn = 1'b0;
    endtask

    task automatic fend();
        #H;
        bus.csn = 1'b1;
        #(3 * H);
    endtask

    task automatic cmd1(input logic [7:0] op);
        logic [7:0] d;
        fstart(); spi_byte(op, d); fend();
    endtask

    task automatic rdsr(output logic [7:0] s);
        logic [7:0] d;
        fstart(); spi_byte(8'h05, d); spi_byte(8'h00, s); fend();
    endtask

    task automatic write1(input logic [7:0] a, input logic [7:0] v);
        logic [7:0] d;
        fstart(); spi_byte(8'h02, d); spi_byte(a, d); spi_byte(v, d); fend();
    endtask

    task automatic read1(input logic [7:0] a, output logic [7:0] v);
        logic [7:0] d;
        fstart(); spi_byte(8'h03, d); spi_byte(a, d); spi_byte(8'h00, v); fend();
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy !== 1'b0 && k < 2000) begin @(negedge clk); k++; end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_idle: busy=%b still set, required 0 within 2000 clk", bus.busy);
        end
    endtask

    task automatic test_reset();
        logic [7:0] s;
        bus.sck = 1'b0; bus.csn = 1'b1; bus.mosi = 1'b0;
        rst_n = 1'b0;
        #20ns;
        n_cmp++; if (bus.miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", bus.miso); end
        n_cmp++; if (bus.miso_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", bus.miso_oe); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        @(negedge clk); rst_n = 1'b1;
        #100ns;
        rdsr(s);
        n_cmp++; if (s !== 8'h00) begin n_bad++; $display("FAIL reset_status: got %h want 00", s); end
    endtask

    task automatic test_wren_rdsr();
        logic [7:0] s;
        cmd1(8'h06);
        rdsr(s);
        n_cmp++; if (s !== 8'h02) begin n_bad++; $display("FAIL wren_rdsr: got %h want 02", s); end
        cmd1(8'h04);
        rdsr(s);
        n_cmp++; if (s !== 8'h00) begin n_bad++; $display("FAIL wrdi_rdsr: got %h want 00", s); end
    endtask

    task automatic test_write_poll();
        logic [7:0] s, first, d;
        int c0;
        bit seen_zero = 0;
        cmd1(8'h06);
        c0 = busy_cyc;
        write1(8'h05, 8'hA5);
        // poll status in a single frame until WIP drops
        fstart();
        spi_byte(8'h05, d);
        spi_byte(8'h00, first);
        for (int i = 0; i < 20 && !seen_zero; i++) begin
            spi_byte(8'h00, s);
            if (s === 8'h00) seen_zero = 1;
        end
        fend();
        n_cmp++; if (first !== 8'h01) begin n_bad++; $display("FAIL poll_first: got %h want 01", first); end
        n_cmp++; if (!seen_zero) begin n_bad++; $display("FAIL poll_clear: last %h want 00", s); end
        n_cmp++; if (busy_cyc - c0 !== WC) begin n_bad++; $display("FAIL wip_cycles: got %0d want %0d", busy_cyc - c0, WC); end
        read1(8'h05, d);
        n_cmp++; if (d !== 8'hA5) begin n_bad++; $display("FAIL read_05: got %h want a5", d); end
    endtask

    task automatic test_write_no_wel();
        logic [7:0] s, d;
        cmd1(8'h06);
        write1(8'h10, 8'h5A);
        wait_idle();
        write1(8'h10, 8'h3C);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL nowel_busy: got %b want 0", bus.busy); end
        rdsr(s);
        n_cmp++; if (s !== 8'h00) begin n_bad++; $display("FAIL nowel_status: got %h want 00", s); end
        read1(8'h10, d);
        n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL nowel_read: got %h want 5a", d); end
    endtask

    task automatic test_page_wrap();
        logic [7:0] d;
        cmd1(8'h06);
        fstart();
        spi_byte(8'h02, d); spi_byte(8'h0E, d);
        spi_byte(8'h11, d); spi_byte(8'h22, d); spi_byte(8'h33, d);
        fend();
        wait_idle();
        read1(8'h0E, d);
        n_cmp++; if (d !== 8'h11) begin n_bad++; $display("FAIL wrap_0e: got %h want 11", d); end
        read1(8'h0F, d);
        n_cmp++; if (d !== 8'h22) begin n_bad++; $display("FAIL wrap_0f: got %h want 22", d); end
        read1(8'h00, d);
        n_cmp++; if (d !== 8'h33) begin n_bad++; $display("FAIL wrap_00: got %h want 33", d); end
        read1(8'h10, d);
        n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL wrap_10: got %h want 5a", d); end
    endtask

    task automatic test_read_wrap();
        logic [7:0] d, b0, b1;
        cmd1(8'h06);
        write1(8'h7F, 8'hC3);
        wait_idle();
        fstart();
        spi_byte(8'h03, d);
        spi_byte(8'h7F, d);
        // the closing fall of the address byte has not propagated yet
        n_cmp++; if (bus.miso_oe !== 1'b0) begin n_bad++; $display("FAIL oe_before: got %b want 0", bus.miso_oe); end
        spi_byte(8'h00, b0);
        n_cmp++; if (bus.miso_oe !== 1'b1) begin n_bad++; $display("FAIL oe_during: got %b want 1", bus.miso_oe); end
        spi_byte(8'h00, b1);
        fend();
        n_cmp++; if (b0 !== 8'hC3) begin n_bad++; $display("FAIL read_7f: got %h want c3", b0); end
        n_cmp++; if (b1 !== 8'h33) begin n_bad++; $display("FAIL read_wrap00: got %h want 33", b1); end
        n_cmp++; if (bus.miso_oe !== 1'b0 || bus.miso !== 1'b0) begin
            n_bad++; $display("FAIL oe_after: got oe=%b miso=%b want 0/0", bus.miso_oe, bus.miso);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s, d;
        logic r;
        // 9-bit WREN frame has no effect
        fstart(); spi_byte(8'h06, d); spi_bit(1'b0, r); fend();
        rdsr(s);
        n_cmp++; if (s !== 8'h00) begin n_bad++; $display("FAIL wren9: got %h want 00", s); end
        // WRITE with only a partial data byte: WEL stays, no WIP
        cmd1(8'h06);
        fstart();
        spi_byte(8'h02, d); spi_byte(8'h20, d);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
        fend();
        rdsr(s);
        n_cmp++; if (s !== 8'h02) begin n_bad++; $display("FAIL partial: got %h want 02", s); end
        // WREN issued while WIP is set is ignored
        write1(8'h21, 8'h44);
        cmd1(8'h06);
        wait_idle();
        rdsr(s);
        n_cmp++; if (s !== 8'h00) begin n_bad++; $display("FAIL wren_wip: got %h want 00", s); end
        read1(8'h21, d);
        n_cmp++; if (d !== 8'h44) begin n_bad++; $display("FAIL read_21: got %h want 44", d); end
    endtask

    task automatic test_wrsr();
        logic [7:0] s, d;
`ifdef SPI_EEPROM_WRSR_EN
        cmd1(8'h06);
        write1(8'h70, 8'h77);
        wait_idle();
        cmd1(8'h06);
        fstart(); spi_byte(8'h01, d); spi_byte(8'h04, d); fend();
        wait_idle();
        cmd1(8'h06);
        write1(8'h70, 8'hFF);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL prot_busy: got %b want 0", bus.busy); end
        rdsr(s);
        // blocked byte is not a completed write, so WEL is left as it was
        n_cmp++; if ((s & 8'hFD) !== 8'h04) begin n_bad++; $display("FAIL prot_status: got %h want 04 (WEL ignored)", s); end
        read1(8'h70, d);
        n_cmp++; if (d !== 8'h77) begin n_bad++; $display("FAIL prot_mem: got %h want 77", d); end
`else
        cmd1(8'h06);
        fstart(); spi_byte(8'h01, d); spi_byte(8'h0C, d); fend();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL op01_busy: got %b want 0", bus.busy); end
        rdsr(s);
        n_cmp++; if (s !== 8'h02) begin n_bad++; $display("FAIL op01_status: got %h want 02", s); end
        cmd1(8'h04);
`endif
    endtask

    initial begin
        test_reset();
        test_wren_rdsr();
        test_write_poll();
        test_write_no_wel();
        test_page_wrap();
        test_read_wrap();
        test_back_to_back();
        test_wrsr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
